enemy_swarm_ctrl: RTL

- Formation controller that drives the enemy sprite drawers.
- Owns the swarm origin, march direction, descend pulses, per-enemy alive mask and wave/game-over status.
- Consumes kill events from collision logic.
- Produces the enemy_direction_X/Y, start and delete_enemies controls that every per-enemy drawer consumes.
- Runs once per video frame on frame_clk.

---
 rtl/swarm_pkg.sv | 34 +++
 rtl/swarm_bounds.sv | 59 +++++
 rtl/enemy_swarm_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/swarm_pkg.sv
// Shared types and default geometry for the enemy swarm controller.
package swarm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        MARCH,
        DESCEND,
        CLEARED,
        INVADED
    } swarm_state_t;

    localparam int unsigned DEF_ROWS        = 4;
    localparam int unsigned DEF_COLS        = 8;
    localparam int unsigned DEF_PITCH_X     = 60;
    localparam int unsigned DEF_PITCH_Y     = 55;
    localparam int unsigned DEF_SPRITE_W    = 50;
    localparam int unsigned DEF_SPRITE_H    = 50;
    localparam int unsigned DEF_START_X     = 40;
    localparam int unsigned DEF_START_Y     = 40;
    localparam int unsigned DEF_STEP_X      = 4;
    localparam int unsigned DEF_STEP_Y      = 20;
    localparam int unsigned DEF_STEP_DIV    = 8;
    localparam int unsigned DEF_LEFT_LIMIT  = 8;
    localparam int unsigned DEF_RIGHT_LIMIT = 632;
    localparam int unsigned DEF_INVADE_Y    = 400;
    localparam int unsigned DEF_CLEAR_WAIT  = 60;

    function automatic int unsigned swarm_idx(input int unsigned r, input int unsigned c,
                                              input int unsigned cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/swarm_bounds.sv
// Occupied-extent finder: leftmost/rightmost alive column, lowest alive row
// and the alive popcount, all combinational from the alive mask.
module swarm_bounds
    import swarm_pkg::*;
#(
    parameter int unsigned ROWS = DEF_ROWS,
    parameter int unsigned COLS = DEF_COLS
) (
    input  logic [ROWS*COLS-1:0]           alive_mask,
    output logic [$clog2(COLS)-1:0]        leftmost_col,
    output logic [$clog2(COLS)-1:0]        rightmost_col,
    output logic [$clog2(ROWS)-1:0]        bottom_row,
    output logic [$clog2(ROWS*COLS+1)-1:0] alive_count
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned NW = $clog2(ROWS*COLS+1);

    logic [COLS-1:0] col_any;
    logic [ROWS-1:0] row_any;

    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (alive_mask[swarm_idx(r, c, COLS)]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end
    end

    // Later loop iterations win, so scan direction picks the extreme index.
    always_comb begin
        leftmost_col  = '0;
        rightmost_col = '0;
        bottom_row    = '0;
        for (int unsigned c = COLS; c > 0; c--) begin
            if (col_any[c-1]) leftmost_col = CW'(c - 1);
        end
        for (int unsigned c = 0; c < COLS; c++) begin
            if (col_any[c]) rightmost_col = CW'(c);
        end
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (row_any[r]) bottom_row = RW'(r);
        end
    end

    always_comb begin
        alive_count = '0;
        for (int unsigned i = 0; i < ROWS*COLS; i++) begin
            alive_count = alive_count + NW'(alive_mask[i]);
        end
    end

endmodule

// File: rtl/enemy_swarm_ctrl.sv
// Enemy formation controller: march, descend, kills, wave clear and invasion.
// Optional SWARM_SPEEDUP_EN shortens the step period as the swarm thins out.
module enemy_swarm_ctrl
    import swarm_pkg::*;
#(
    parameter int unsigned ROWS        = DEF_ROWS,
    parameter int unsigned COLS        = DEF_COLS,
    parameter int unsigned PITCH_X     = DEF_PITCH_X,
    parameter int unsigned PITCH_Y     = DEF_PITCH_Y,
    parameter int unsigned SPRITE_W    = DEF_SPRITE_W,
    parameter int unsigned SPRITE_H    = DEF_SPRITE_H,
    parameter int unsigned START_X     = DEF_START_X,
    parameter int unsigned START_Y     = DEF_START_Y,
    parameter int unsigned STEP_X      = DEF_STEP_X,
    parameter int unsigned STEP_Y      = DEF_STEP_Y,
    parameter int unsigned STEP_DIV    = DEF_STEP_DIV,
    parameter int unsigned LEFT_LIMIT  = DEF_LEFT_LIMIT,
    parameter int unsigned RIGHT_LIMIT = DEF_RIGHT_LIMIT,
    parameter int unsigned INVADE_Y    = DEF_INVADE_Y,
    parameter int unsigned CLEAR_WAIT  = DEF_CLEAR_WAIT
) (
    input  logic                           frame_clk,
    input  logic                           Reset,
    input  logic                           start_game,
    input  logic                           kill_valid,
    input  logic [$clog2(ROWS)-1:0]        kill_row,
    input  logic [$clog2(COLS)-1:0]        kill_col,
    output logic [9:0]                     swarm_x,
    output logic [9:0]                     swarm_y,
    output logic                           enemy_direction_X,
    output logic                           enemy_direction_Y,
    output logic                           start,
    output logic                           delete_enemies,
    output logic [ROWS*COLS-1:0]           alive_mask,
    output logic [$clog2(ROWS*COLS+1)-1:0] alive_count,
    output logic                           wave_cleared,
    output logic                           invaded
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned TW = $clog2(STEP_DIV + 1);
    localparam int unsigned WW = $clog2(CLEAR_WAIT + 1);

    swarm_state_t        state;
    logic [TW-1:0]       timer;
    logic [WW-1:0]       wait_cnt;
    logic [CW-1:0]       leftmost_col;
    logic [CW-1:0]       rightmost_col;
    logic [RW-1:0]       bottom_row;
    logic [ROWS*COLS-1:0] mask_next;
    logic [10:0]         right_edge;
    logic [10:0]         left_edge;
    logic [10:0]         bottom_edge;
    logic                edge_hit;
    logic                invade_hit;
    logic                step_due;
    logic                spawn_req;

    swarm_bounds #(
        .ROWS(ROWS),
        .COLS(COLS)
    ) u_bounds (
        .alive_mask   (alive_mask),
        .leftmost_col (leftmost_col),
        .rightmost_col(rightmost_col),
        .bottom_row   (bottom_row),
        .alive_count  (alive_count)
    );

    // Out-of-range row/column indices simply match no enemy.
    always_comb begin
        mask_next = alive_mask;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (kill_valid && 32'(kill_row) == r && 32'(kill_col) == c)
                    mask_next[swarm_idx(r, c, COLS)] = 1'b0;
            end
        end
    end

    assign right_edge  = {1'b0, swarm_x} + 11'(rightmost_col) * 11'(PITCH_X) + 11'(SPRITE_W + STEP_X);
    assign left_edge   = {1'b0, swarm_x} + 11'(leftmost_col) * 11'(PITCH_X);
    assign bottom_edge = {1'b0, swarm_y} + 11'(bottom_row) * 11'(PITCH_Y) + 11'(SPRITE_H);
    assign edge_hit    = enemy_direction_X ? (right_edge > 11'(RIGHT_LIMIT))
                                           : (left_edge < 11'(LEFT_LIMIT + STEP_X));
    assign invade_hit  = (bottom_edge >= 11'(INVADE_Y));

`ifdef SWARM_SPEEDUP_EN
    logic [TW-1:0] period;

    // period = max(1, floor(STEP_DIV*count/N)) via threshold compares.
    always_comb begin
        period = TW'(1);
        for (int unsigned k = 2; k <= STEP_DIV; k++) begin
            if (32'(alive_count) * STEP_DIV >= k * ROWS * COLS) period = TW'(k);
        end
    end
    assign step_due = (timer + TW'(1) >= period);
`else
    assign step_due = (timer == TW'(STEP_DIV - 1));
`endif

    assign spawn_req = ((state == IDLE || state == INVADED) && start_game) ||
                       (state == CLEARED && wait_cnt == WW'(CLEAR_WAIT - 1));

    // The Y step and X reversal land on the edge into DESCEND so drawers see
    // them together with enemy_direction_Y during the descend frame.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state             <= IDLE;
            swarm_x           <= 10'(START_X);
            swarm_y           <= 10'(START_Y);
            enemy_direction_X <= 1'b1;
            enemy_direction_Y <= 1'b0;
            start             <= 1'b0;
            delete_enemies    <= 1'b1;
            alive_mask        <= '1;
            wave_cleared      <= 1'b0;
            invaded           <= 1'b0;
            timer             <= '0;
            wait_cnt          <= '0;
        end else begin
            case (state)
                SPAWN: begin
                    start <= 1'b0;
                    state <= MARCH;
                end
                MARCH: begin
                    alive_mask <= mask_next;
                    if (mask_next == '0) begin
                        state        <= CLEARED;
                        wave_cleared <= 1'b1;
                        wait_cnt     <= '0;
                    end else if (step_due) begin
                        timer <= '0;
                        if (edge_hit) begin
                            state             <= DESCEND;
                            swarm_y           <= swarm_y + 10'(STEP_Y);
                            enemy_direction_X <= ~enemy_direction_X;
                            enemy_direction_Y <= 1'b1;
                        end else if (enemy_direction_X) begin
                            swarm_x <= swarm_x + 10'(STEP_X);
                        end else begin
                            swarm_x <= swarm_x - 10'(STEP_X);
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DESCEND: begin
                    alive_mask        <= mask_next;
                    enemy_direction_Y <= 1'b0;
                    if (mask_next == '0) begin
                        state        <= CLEARED;
                        wave_cleared <= 1'b1;
                        wait_cnt     <= '0;
                    end else if (invade_hit) begin
                        state          <= INVADED;
                        invaded        <= 1'b1;
                        delete_enemies <= 1'b1;
                    end else begin
                        state <= MARCH;
                    end
                end
                CLEARED: begin
                    wave_cleared <= 1'b0;
                    wait_cnt     <= wait_cnt + WW'(1);
                end
                default: ;
            endcase

            if (spawn_req) begin
                state             <= SPAWN;
                swarm_x           <= 10'(START_X);
                swarm_y           <= 10'(START_Y);
                alive_mask        <= '1;
                enemy_direction_X <= 1'b1;
                enemy_direction_Y <= 1'b0;
                timer             <= '0;
                start             <= 1'b1;
                delete_enemies    <= 1'b0;
                invaded           <= 1'b0;
                wave_cleared      <= 1'b0;
            end
        end
    end

endmodule
